mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//   Multi-cycle signed multiply/divide engine on the ALU side of the datapath.
//   Consumes operand A (Y register output) and operand B (bus value).
//   Produces a 64-bit result for the Z register pair: result_hi -> ZHigh, result_lo -> ZLow.
//   The control sequencer starts an operation and waits for done before asserting the Z-register enables.
// PARAMETERS
//   WIDTH  32  operand width; results are 2*WIDTH split into hi/lo halves
// PORTS
//   clock        in   1      rising-edge clock
//   clear        in   1      asynchronous, active-high reset
//   start        in   1      request operation; sampled only when not busy
//   op           in   1      0 = signed multiply, 1 = signed divide
//   a            in   WIDTH  multiplicand / dividend (two's complement)
//   b            in   WIDTH  multiplier / divisor (two's complement)
//   busy         out  1      operation in progress
//   done         out  1      one-cycle pulse: results valid
//   result_hi    out  WIDTH  MUL: product[2W-1:W]; DIV: remainder
//   result_lo    out  WIDTH  MUL: product[W-1:0]; DIV: quotient
//   div_by_zero  out  1      set with done when op=1 and b==0
// BEHAVIOUR
//   - One clock; clear is asynchronous and active-high.
//   - Reset, while clear is high: state=IDLE; busy, done, div_by_zero, result_hi, result_lo, iteration counter all 0.
//   - States: IDLE, MUL, DIV, FIN.
//   - Start acceptance (edge E0):
//     - start=1 in IDLE or FIN latches a, b, op.
//     - Next state: MUL, or DIV; divide with b==0 goes directly to FIN.
//     - Counter cleared; busy=1 from E0.
//   - start while MUL/DIV: ignored; the latched operands are unaffected by input changes.
//   - MUL: radix-2 Booth, one iteration per edge, WIDTH iterations.
//     - Product is the full 2W-bit signed product; no overflow is possible.
//   - DIV: restoring division on operand magnitudes, one quotient bit per edge, WIDTH iterations.
//     - Sign fix applied when entering FIN:
//       - Quotient truncates toward zero.
//       - Remainder takes the sign of the dividend.
//       - Always a == q*b + r, with |r| < |b|.
//   - Overflow case a = -2^(W-1), b = -1: quotient wraps to -2^(W-1) (0x80000000); remainder 0; no flag.
//   - Divide by zero: FIN entered at E0+1 with result_lo = all ones, result_hi = a, div_by_zero = 1.
//   - Latency: for MUL/DIV the edge E0+WIDTH enters FIN.
//     - done=1 and busy=0 for the cycle following that edge: WIDTH+1 cycles after start, or 2 for div-by-zero.
//     - done deasserts on the next edge.
//   - Results and div_by_zero are updated only on entry to FIN.
//     - They hold until the next accepted start, which clears div_by_zero.
//     - result_hi/lo are not modified during iterations; internal accumulators are separate.
//   - Back-to-back: start=1 during the FIN cycle is accepted at that edge; done still falls.
//   - FIN with no start returns to IDLE; outputs are held.
//   - clear asserted mid-operation aborts immediately to the reset state; no done pulse is produced.
// TESTING
//   - MUL 7 x -3 -> done at cycle 33 after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//   - MUL 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000; MUL 0x7FFFFFFF x 0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
//   - DIV sign cases:
//     - -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//     - 7 / -2 -> lo=-3, hi=1.
//     - 0x80000000 / -1 -> lo=0x80000000, hi=0.
//   - DIV 5 / 0 -> done 2 cycles after start, div_by_zero=1, lo=0xFFFFFFFF, hi=5.
//     - A subsequent MUL start clears div_by_zero.
//   - Start 100/7, toggle start and change a/b mid-run -> ignored; lo=14, hi=2.
//     - start held during FIN launches a second op (MUL 3x4 -> lo=12) with no idle gap.
//   - Assert clear at iteration 10 of a MUL -> busy, done, results 0 asynchronously; no done pulse.
//     - A new start after release completes normally.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring, magnitude based) engine.
// One iteration per clock; results land in result_hi/lo only on entry to FIN, with done pulsing there.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic             r_qm1;

  logic             w_accept;
  logic             w_last;
  logic             w_dbz;
  logic [WIDTH-1:0] w_in_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_mul_hi_nxt;
  logic [WIDTH-1:0] w_mul_lo_nxt;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_div_hi_nxt;
  logic [WIDTH-1:0] w_div_lo_nxt;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  assign w_accept   = start && (r_state == S_IDLE || r_state == S_FIN);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_dbz      = (r_b == '0);
  assign w_in_a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign w_b_mag    = r_b[WIDTH-1] ? (~r_b + 1'b1) : r_b;

  // Booth: accumulator high half carries one guard bit so that subtracting -2^(W-1) cannot overflow.
  assign w_m_ext = {r_a[WIDTH-1], r_a};

  always_comb begin
    w_booth_sum = r_acc_hi;
    case ({r_acc_lo[0], r_qm1})
      2'b01:   w_booth_sum = r_acc_hi + w_m_ext;
      2'b10:   w_booth_sum = r_acc_hi - w_m_ext;
      default: w_booth_sum = r_acc_hi;
    endcase
  end

  assign w_mul_hi_nxt = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
  assign w_mul_lo_nxt = {w_booth_sum[0], r_acc_lo[WIDTH-1:1]};

  // Restoring step: remainder in r_acc_hi, dividend magnitude shifting out of r_acc_lo as quotient shifts in.
  assign w_shift      = {r_acc_hi[WIDTH-1:0], r_acc_lo[WIDTH-1]};
  assign w_trial      = w_shift - {1'b0, w_b_mag};
  assign w_div_hi_nxt = w_trial[WIDTH] ? w_shift : w_trial;
  assign w_div_lo_nxt = {r_acc_lo[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_quot       = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? (~w_div_lo_nxt + 1'b1) : w_div_lo_nxt;
  assign w_rem        = r_a[WIDTH-1] ? (~w_div_hi_nxt[WIDTH-1:0] + 1'b1) : w_div_hi_nxt[WIDTH-1:0];

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = op ? S_DIV : S_MUL;
      end
      S_MUL: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_FIN;
      end
      S_DIV: begin
        busy = 1'b1;
        if (w_dbz || w_last) w_state_nxt = S_FIN;
      end
      S_FIN: begin
        done = 1'b1;
        if (w_accept) w_state_nxt = op ? S_DIV : S_MUL;
        else          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_acc_hi    <= '0;
      r_acc_lo    <= '0;
      r_qm1       <= 1'b0;
      result_hi   <= '0;
      result_lo   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a         <= a;
        r_b         <= b;
        r_cnt       <= '0;
        r_acc_hi    <= '0;
        r_acc_lo    <= op ? w_in_a_mag : b;
        r_qm1       <= 1'b0;
        div_by_zero <= 1'b0;
      end else begin
        case (r_state)
          S_MUL: begin
            r_acc_hi <= w_mul_hi_nxt;
            r_acc_lo <= w_mul_lo_nxt;
            r_qm1    <= r_acc_lo[0];
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
              result_hi <= w_mul_hi_nxt[WIDTH-1:0];
              result_lo <= w_mul_lo_nxt;
            end
          end
          S_DIV: begin
            if (w_dbz) begin
              result_hi   <= r_a;
              result_lo   <= '1;
              div_by_zero <= 1'b1;
            end else begin
              r_acc_hi <= w_div_hi_nxt;
              r_acc_lo <= w_div_lo_nxt;
              r_cnt    <= r_cnt + CW'(1);
              if (w_last) begin
                result_hi <= w_rem;
                result_lo <= w_quot;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
